// File: rtl/and_gate_pipe_if.sv
// Operand/result handshake bundle for and_gate_pipe.
// The producer/consumer side uses the master modport; the block itself uses slave.
interface and_gate_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_all, y_any
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, y_all, y_any
  );
endinterface

// File: rtl/and_gate_pipe.sv
// Registered bitwise-op stage with valid/ready handshake on both sides.
// Computes an AND-family op (or a running-AND accumulator step) on two WIDTH-bit
// operands, holds the result until the consumer takes it, and reports its
// AND/OR reductions alongside.
module and_gate_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  and_gate_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ACC  = 3'b110,
    OP_LOAD = 3'b111
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_y_all;
  logic             r_y_any;
  logic [WIDTH-1:0] r_acc;

  op_e              w_op;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  logic [WIDTH-1:0] w_f;
  logic             w_acc_we;

  // Output slot is free when empty or being drained this cycle.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_op       = op_e'(bus.op);

  // Result function and accumulator write-enable for the current beat.
  always_comb begin
    w_f      = '0;
    w_acc_we = 1'b0;
    case (w_op)
      OP_AND:  w_f = bus.a & bus.b;
      OP_OR:   w_f = bus.a | bus.b;
      OP_XOR:  w_f = bus.a ^ bus.b;
      OP_NAND: w_f = ~(bus.a & bus.b);
      OP_NOR:  w_f = ~(bus.a | bus.b);
      OP_XNOR: w_f = ~(bus.a ^ bus.b);
      OP_ACC: begin
        w_f      = r_acc & bus.a & bus.b;
        w_acc_we = 1'b1;
      end
      OP_LOAD: begin
        w_f      = bus.a & bus.b;
        w_acc_we = 1'b1;
      end
      default: w_f = '0;
    endcase
  end

  // Output register: load on accept, clear valid on drain-only, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_all     <= 1'b0;
      r_y_any     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_f;
      r_y_all     <= &w_f;
      r_y_any     <= |w_f;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator: only accepted ACC/LOAD beats write it; reset reloads all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '1;
    end else if (w_accept && w_acc_we) begin
      r_acc <= w_f;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.y_all     = r_y_all;
  assign bus.y_any     = r_y_any;

endmodule
